mbus_rx_queue_ice: RTL
======================

// Module: mbus_rx_queue_ice
// PURPOSE
//  Receive-side message buffer directly downstream of the MBus layer wrapper: consumes RX_ADDR/RX_DATA/RX_REQ/RX_PEND/
//  RX_BROADCAST/RX_FAIL, returns RX_ACK (4-phase), stores words in a FIFO and exposes only fully received (committed)
//  messages to the layer controller via valid/ready. Aborted or oversize messages are discarded atomically.
// PARAMETERS
//  ADDR_W  32  width of RX_ADDR / Q_ADDR
//  DATA_W  32  width of RX_DATA / Q_DATA
//  DEPTH   8   FIFO entries (words); power of 2, >=2
//  PTR_W   3   log2(DEPTH)
// PORTS
//  CLKIN         in   1       bus-side clock; all state on rising edge
//  RESETn        in   1       reset, asynchronous assert, active-low
//  RX_ADDR       in   ADDR_W  word address from node
//  RX_DATA       in   DATA_W  word data from node
//  RX_REQ        in   1       word available (4-phase request)
//  RX_PEND       in   1       1 = more words follow in this message
//  RX_BROADCAST  in   1       message is broadcast
//  RX_FAIL       in   1       current message aborted by bus
//  RX_ACK        out  1       word accepted (4-phase acknowledge)
//  Q_VALID       out  1       committed word at head
//  Q_READY       in   1       consumer pops head when Q_VALID&Q_READY
//  Q_ADDR        out  ADDR_W  head address
//  Q_DATA        out  DATA_W  head data
//  Q_LAST        out  1       head is last word of its message
//  Q_BCAST       out  1       head belongs to broadcast message
//  MSG_DROP      out  1       one-cycle pulse: a message was discarded
// BEHAVIOUR
//  Clocking/reset: one clock; reset is asynchronous and active-low. Reset: RX_ACK=0, Q_VALID=0, MSG_DROP=0, all pointers=0,
//   state=IDLE; Q_ADDR/Q_DATA/Q_LAST/Q_BCAST = 0 (head entry reads as zero). Reset mid-message discards all content.
//  Pointers: wr_ptr (speculative), cm_ptr (commit), rd_ptr; PTR_W+1 bits each, MSB = wrap bit. full: wr_ptr-rd_ptr==DEPTH.
//   Q_VALID = (cm_ptr != rd_ptr); pop advances rd_ptr the same cycle; Q_* driven combinationally from rd_ptr entry.
//  FSM states: IDLE, ACK, DISCARD, DACK.
//   IDLE: RX_REQ=1 & !full -> write {addr,data,!RX_PEND,bcast} at wr_ptr, wr_ptr+1; if RX_PEND=0 cm_ptr<=wr_ptr+1;
//         RX_ACK<=1, ->ACK. RX_REQ=1 & full: if wr_ptr-cm_ptr==DEPTH (message alone fills FIFO) -> wr_ptr<=cm_ptr,
//         MSG_DROP pulse, ->DISCARD; else stall (RX_ACK held 0) until a pop frees space.
//   ACK: RX_ACK=1 until RX_REQ=0, then RX_ACK<=0, ->IDLE. Min latency REQ rise -> ACK rise = 1 cycle.
//   DISCARD: RX_REQ=1 -> RX_ACK<=1, word dropped, remember RX_PEND, ->DACK. DACK: on RX_REQ=0 drop ACK; ->IDLE if
//         remembered RX_PEND=0, else ->DISCARD.
//  RX_FAIL (any state, level sampled): wr_ptr<=cm_ptr, RX_ACK<=0, ->IDLE, MSG_DROP pulse if wr_ptr!=cm_ptr or state was
//   DISCARD/DACK. RX_FAIL in same cycle as an IDLE capture: fail wins, word not written, no ACK.
//  Simultaneous pop and write allowed; full evaluated on pre-update pointers. Pop with Q_VALID=0 ignored.
//  Committed messages are never touched by RX_FAIL or discard.
// CONFIGURATION
//  MBUS_RXQ_DROP_CNT_EN: defined -> extra output DROP_CNT [7:0], increments on every MSG_DROP pulse, saturates at 8'hFF,
//   reset 0, cleared by 1-cycle input DROP_CNT_CLR (clear wins over simultaneous increment). Undefined -> neither port exists,
//   no counter logic; all other behaviour identical.
// TESTING
//  T1 single word: REQ with addr=32'hA5, data=32'h1234, PEND=0 -> ACK 1 cycle later; Q_VALID=1, Q_LAST=1, Q_DATA=32'h1234.
//  T2 3-word msg, Q_READY=0: Q_VALID stays 0 until 3rd word (PEND=0) acked; then 3 pops give LAST=0,0,1.
//  T3 RX_FAIL after 2 of 4 words, with one committed msg queued -> MSG_DROP pulse, uncommitted words gone, committed msg
//     intact; next message stored from old cm_ptr.
//  T4 full stall: 8 committed words, Q_READY=0, new REQ -> RX_ACK stays 0; one pop -> ACK within 2 cycles.
//  T5 oversize: 10-word msg, DEPTH=8, empty queue -> MSG_DROP after 8 stored, all 10 acked, Q_VALID never 1; next msg OK.
//  T6 async reset during ACK state -> RX_ACK, Q_VALID 0 immediately; with MBUS_RXQ_DROP_CNT_EN: 300 drops -> DROP_CNT=8'hFF.

Source files
------------

// File: rtl/mbus_rx_queue_ice.sv
// rtl/mbus_rx_queue_ice.sv - MBus receive message queue with commit/discard semantics.
// Optional saturating drop counter enabled by MBUS_RXQ_DROP_CNT_EN.
module mbus_rx_queue_ice #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              CLKIN,
  input  logic              RESETn,
`ifdef MBUS_RXQ_DROP_CNT_EN
  input  logic              DROP_CNT_CLR,
  output logic [7:0]        DROP_CNT,
`endif
  input  logic [ADDR_W-1:0] RX_ADDR,
  input  logic [DATA_W-1:0] RX_DATA,
  input  logic              RX_REQ,
  input  logic              RX_PEND,
  input  logic              RX_BROADCAST,
  input  logic              RX_FAIL,
  output logic              RX_ACK,
  output logic              Q_VALID,
  input  logic              Q_READY,
  output logic [ADDR_W-1:0] Q_ADDR,
  output logic [DATA_W-1:0] Q_DATA,
  output logic              Q_LAST,
  output logic              Q_BCAST,
  output logic              MSG_DROP
);

  typedef enum logic [1:0] {IDLE, ACK, DISCARD, DACK} state_t;

  localparam logic [PTR_W:0] PTR_ONE   = 1;
  localparam logic [PTR_W:0] PTR_DEPTH = DEPTH[PTR_W:0];

  state_t           state_q, state_d;
  logic [PTR_W:0]   wr_q, wr_d;
  logic [PTR_W:0]   cm_q, cm_d;
  logic [PTR_W:0]   rd_q, rd_d;
  logic             ack_q, ack_d;
  logic             pend_q, pend_d;
  logic             drop_q, drop_d;
  logic             we;
  logic             full;
  logic             msg_fills;
  logic             pop;

  logic [ADDR_W-1:0] addr_mem_q  [DEPTH];
  logic [DATA_W-1:0] data_mem_q  [DEPTH];
  logic              last_mem_q  [DEPTH];
  logic              bcast_mem_q [DEPTH];

  assign full      = (wr_q - rd_q) == PTR_DEPTH;
  assign msg_fills = (wr_q - cm_q) == PTR_DEPTH;
  assign Q_VALID   = (cm_q != rd_q);
  assign pop       = Q_VALID & Q_READY;
  assign rd_d      = pop ? rd_q + PTR_ONE : rd_q;

  assign Q_ADDR    = addr_mem_q[rd_q[PTR_W-1:0]];
  assign Q_DATA    = data_mem_q[rd_q[PTR_W-1:0]];
  assign Q_LAST    = last_mem_q[rd_q[PTR_W-1:0]];
  assign Q_BCAST   = bcast_mem_q[rd_q[PTR_W-1:0]];
  assign RX_ACK    = ack_q;
  assign MSG_DROP  = drop_q;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    cm_d    = cm_q;
    ack_d   = ack_q;
    pend_d  = pend_q;
    drop_d  = 1'b0;
    we      = 1'b0;
    // Abort rolls the speculative pointer back; committed words are untouched.
    if (RX_FAIL) begin
      wr_d    = cm_q;
      ack_d   = 1'b0;
      state_d = IDLE;
      drop_d  = (wr_q != cm_q) || (state_q == DISCARD) || (state_q == DACK);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (RX_REQ) begin
            if (!full) begin
              we      = 1'b1;
              wr_d    = wr_q + PTR_ONE;
              if (!RX_PEND) cm_d = wr_q + PTR_ONE;
              ack_d   = 1'b1;
              state_d = ACK;
            end else if (msg_fills) begin
              wr_d    = cm_q;
              drop_d  = 1'b1;
              state_d = DISCARD;
            end
          end
        end
        ACK: begin
          if (!RX_REQ) begin
            ack_d   = 1'b0;
            state_d = IDLE;
          end
        end
        DISCARD: begin
          if (RX_REQ) begin
            ack_d   = 1'b1;
            pend_d  = RX_PEND;
            state_d = DACK;
          end
        end
        DACK: begin
          if (!RX_REQ) begin
            ack_d   = 1'b0;
            state_d = pend_q ? DISCARD : IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= IDLE;
      wr_q    <= '0;
      cm_q    <= '0;
      rd_q    <= '0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cm_q    <= cm_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  // Storage is cleared on reset so an empty queue presents an all-zero head.
  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i]  <= '0;
        data_mem_q[i]  <= '0;
        last_mem_q[i]  <= 1'b0;
        bcast_mem_q[i] <= 1'b0;
      end
    end else if (we) begin
      addr_mem_q[wr_q[PTR_W-1:0]]  <= RX_ADDR;
      data_mem_q[wr_q[PTR_W-1:0]]  <= RX_DATA;
      last_mem_q[wr_q[PTR_W-1:0]]  <= !RX_PEND;
      bcast_mem_q[wr_q[PTR_W-1:0]] <= RX_BROADCAST;
    end
  end

`ifdef MBUS_RXQ_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge CLKIN or negedge RESETn) begin
    if (!RESETn) begin
      drop_cnt_q <= 8'h00;
    end else if (DROP_CNT_CLR) begin
      drop_cnt_q <= 8'h00;
    end else if (drop_q && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'h01;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`endif

endmodule
